// File: rtl/friscv_pkg.sv
// Shared types for the data-memory controller: access size, controller FSM
// states, and the alignment rule used to reject bad requests.
package friscv_pkg;

  localparam int unsigned ARCH = 32;

  typedef enum logic [1:0] {
    MEM_BYTE    = 2'b00,
    MEM_HALF    = 2'b01,
    MEM_WORD    = 2'b10,
    MEM_ILLEGAL = 2'b11
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_MERGE   = 3'd3,
    ST_WRITE   = 3'd4,
    ST_RESP    = 3'd5
  } dmem_state_t;

  // Natural alignment check; the illegal size code always fails.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lane);
    logic bad;
    case (size)
      MEM_BYTE: bad = 1'b0;
      MEM_HALF: bad = lane[0];
      MEM_WORD: bad = |lane;
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering for the data memory: extracts/extends load data and merges
// sub-word store data into a read word (little-endian byte lanes).
module mem_align
  import friscv_pkg::*;
#(
  parameter int unsigned DATA_W = ARCH
) (
  input  logic [DATA_W-1:0] rdata_in,
  input  logic [1:0]        lane_in,
  input  mem_size_t         size_in,
  input  logic              unsigned_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] merged_c
);

  logic [4:0]        shift;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;

  always_comb begin
    shift       = {lane_in, 3'b000};
    shifted     = rdata_in >> shift;
    load_data_c = shifted;
    mask        = '1;
    case (size_in)
      MEM_BYTE: begin
        load_data_c = unsigned_in ? DATA_W'(shifted[7:0])
                                  : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
        mask        = DATA_W'(8'hFF) << shift;
      end
      MEM_HALF: begin
        load_data_c = unsigned_in ? DATA_W'(shifted[15:0])
                                  : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
        mask        = DATA_W'(16'hFFFF) << shift;
      end
      default: ;
    endcase
    merged_c = (rdata_in & ~mask) | ((wdata_in << shift) & mask);
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one request at a time against a dual-port SRAM,
// loads via the read port, sub-word stores via read-modify-write.
module dmem_ctrl
  import friscv_pkg::*;
#(
  parameter int unsigned DATA_W = ARCH,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              req_we_in,
  input  logic [1:0]        req_size_in,
  input  logic              req_unsigned_in,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [DATA_W-1:0] req_wdata_in,
  output logic              rsp_valid_out,
  input  logic              rsp_ready_in,
  output logic [DATA_W-1:0] rsp_rdata_out,
  output logic              rsp_err_out,
  output logic [ADDR_W-1:0] sram_addr_a_out,
  output logic [DATA_W-1:0] sram_din_a_out,
  output logic              sram_we_a_out,
  output logic [ADDR_W-1:0] sram_addr_b_out,
  output logic              sram_en_b_out,
  input  logic [DATA_W-1:0] sram_dout_b_in
);

  dmem_state_t       state_q, state_d;
  logic              we_q, we_d;
  mem_size_t         size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lane_q, lane_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_a_q, we_a_d;
  logic              en_b_q, en_b_d;

  logic [DATA_W-1:0] load_data_c;
  logic [DATA_W-1:0] merged_c;
  logic              req_fire;
  mem_size_t         req_size;

  mem_align #(.DATA_W(DATA_W)) u_align (
    .rdata_in    (sram_dout_b_in),
    .lane_in     (lane_q),
    .size_in     (size_q),
    .unsigned_in (uns_q),
    .wdata_in    (wdata_q),
    .load_data_c (load_data_c),
    .merged_c    (merged_c)
  );

  assign req_fire = req_valid_in & ready_q;
  assign req_size = mem_size_t'(req_size_in);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    sram_addr_d = sram_addr_q;
    din_d       = din_q;
    we_a_d      = 1'b0;
    en_b_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          we_d    = req_we_in;
          size_d  = req_size;
          uns_d   = req_unsigned_in;
          lane_d  = req_addr_in[1:0];
          wdata_d = req_wdata_in;
          if (is_misaligned(req_size, req_addr_in[1:0])) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            sram_addr_d = {req_addr_in[ADDR_W-1:2], 2'b00};
            if (req_we_in && req_size == MEM_WORD) begin
              state_d = ST_WRITE;
              we_a_d  = 1'b1;
              din_d   = req_wdata_in;
            end else begin
              state_d = ST_READ;
              en_b_d  = 1'b1;
            end
          end
        end
      end
      ST_READ: begin
        // Read data arrives next cycle; a sub-word store writes it back then.
        if (we_q) begin
          state_d = ST_MERGE;
          we_a_d  = 1'b1;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = load_data_c;
      end
      ST_MERGE, ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      ST_RESP: begin
        if (rsp_ready_in) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= MEM_BYTE;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      sram_addr_q <= '0;
      din_q       <= '0;
      we_a_q      <= 1'b0;
      en_b_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      sram_addr_q <= sram_addr_d;
      din_q       <= din_d;
      we_a_q      <= we_a_d;
      en_b_q      <= en_b_d;
    end
  end

  assign req_ready_out   = ready_q;
  assign rsp_valid_out   = rsp_valid_q;
  assign rsp_rdata_out   = rsp_rdata_q;
  assign rsp_err_out     = rsp_err_q;
  assign sram_addr_a_out = sram_addr_q;
  assign sram_addr_b_out = sram_addr_q;
  assign sram_we_a_out   = we_a_q;
  assign sram_en_b_out   = en_b_q;
  // Merged word depends on read data that only exists during MERGE.
  assign sram_din_a_out  = (state_q == ST_MERGE) ? merged_c : din_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomised bench for dmem_ctrl: an SRAM model plus a byte-array reference
// memory that predicts load data, error flag, latency and port activity.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_we_in;
  logic [1:0]  req_size_in;
  logic        req_unsigned_in;
  logic [11:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic        rsp_valid_out;
  logic        rsp_ready_in;
  logic [31:0] rsp_rdata_out;
  logic        rsp_err_out;
  logic [11:0] sram_addr_a_out;
  logic [31:0] sram_din_a_out;
  logic        sram_we_a_out;
  logic [11:0] sram_addr_b_out;
  logic        sram_en_b_out;
  logic [31:0] sram_dout_b;

  logic [31:0] sram [1024];
  logic [7:0]  ref_mem [64];
  int          we_cnt = 0;
  int          en_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_in    (req_valid_in),
    .req_ready_out   (req_ready_out),
    .req_we_in       (req_we_in),
    .req_size_in     (req_size_in),
    .req_unsigned_in (req_unsigned_in),
    .req_addr_in     (req_addr_in),
    .req_wdata_in    (req_wdata_in),
    .rsp_valid_out   (rsp_valid_out),
    .rsp_ready_in    (rsp_ready_in),
    .rsp_rdata_out   (rsp_rdata_out),
    .rsp_err_out     (rsp_err_out),
    .sram_addr_a_out (sram_addr_a_out),
    .sram_din_a_out  (sram_din_a_out),
    .sram_we_a_out   (sram_we_a_out),
    .sram_addr_b_out (sram_addr_b_out),
    .sram_en_b_out   (sram_en_b_out),
    .sram_dout_b_in  (sram_dout_b)
  );

  // Dual-port SRAM with one-cycle read latency; also counts port strobes.
  always @(posedge clk) begin
    if (sram_we_a_out) begin
      sram[sram_addr_a_out[11:2]] <= sram_din_a_out;
      we_cnt <= we_cnt + 1;
    end
    if (sram_en_b_out) begin
      sram_dout_b <= sram[sram_addr_b_out[11:2]];
      en_cnt <= en_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".req_ready"}, 32'(req_ready_out), 32'd0);
    check_eq({tag, ".rsp_valid"}, 32'(rsp_valid_out), 32'd0);
    check_eq({tag, ".rsp_rdata"}, rsp_rdata_out, 32'd0);
    check_eq({tag, ".rsp_err"}, 32'(rsp_err_out), 32'd0);
    check_eq({tag, ".we_a"}, 32'(sram_we_a_out), 32'd0);
    check_eq({tag, ".en_b"}, 32'(sram_en_b_out), 32'd0);
    check_eq({tag, ".addr_a"}, 32'(sram_addr_a_out), 32'd0);
    check_eq({tag, ".addr_b"}, 32'(sram_addr_b_out), 32'd0);
    check_eq({tag, ".din_a"}, sram_din_a_out, 32'd0);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!req_ready_out && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("req_ready", 32'(req_ready_out), 32'd1);
  endtask

  // One complete request/response, predicted from the byte-level reference.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] rd);
    int          nb, exp_lat, k, we0, en0, a;
    logic        bad;
    logic [31:0] exp_rd;
    nb     = 1 << size;
    a      = int'(addr);
    bad    = (size == 2'b11) || (a % nb != 0);
    exp_rd = 32'd0;
    if (!bad && !we) begin
      for (int i = 0; i < nb; i++) exp_rd = exp_rd | (32'(ref_mem[a + i]) << (8 * i));
      if (!uns && nb < 4 && exp_rd[8 * nb - 1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8 * nb));
    end
    exp_lat = bad ? 1 : (we && nb == 4) ? 2 : 3;

    wait_ready();
    we0 = we_cnt;
    en0 = en_cnt;
    req_valid_in    = 1'b1;
    req_we_in       = we;
    req_size_in     = size;
    req_unsigned_in = uns;
    req_addr_in     = addr;
    req_wdata_in    = wdata;
    @(posedge clk); #1;
    req_valid_in = 1'b0;
    k = 1;
    while (!rsp_valid_out && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("latency", 32'(k), 32'(exp_lat));
    check_eq("rsp_rdata", rsp_rdata_out, exp_rd);
    check_eq("rsp_err", 32'(rsp_err_out), 32'(bad));
    rd = rsp_rdata_out;

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq("hold.valid", 32'(rsp_valid_out), 32'd1);
      check_eq("hold.rdata", rsp_rdata_out, exp_rd);
      check_eq("hold.err", 32'(rsp_err_out), 32'(bad));
      check_eq("hold.ready", 32'(req_ready_out), 32'd0);
    end
    rsp_ready_in = 1'b1;
    @(posedge clk); #1;
    rsp_ready_in = 1'b0;
    check_eq("post.valid", 32'(rsp_valid_out), 32'd0);
    check_eq("post.ready", 32'(req_ready_out), 32'd1);

    check_eq("we_a_pulses", 32'(we_cnt - we0), 32'(we && !bad));
    check_eq("en_b_pulses", 32'(en_cnt - en0), 32'(!bad && (!we || nb < 4)));

    if (we && !bad)
      for (int i = 0; i < nb; i++) ref_mem[a + i] = 8'(wdata >> (8 * i));
  endtask

  task automatic check_word(input string tag, input int widx);
    logic [31:0] exp;
    exp = {ref_mem[4*widx+3], ref_mem[4*widx+2], ref_mem[4*widx+1], ref_mem[4*widx]};
    check_eq(tag, sram[widx], exp);
  endtask

  initial begin
    logic [31:0] rd;
    int          we0;

    rst_n = 1'b0;
    req_valid_in = 1'b0; req_we_in = 1'b0; req_size_in = 2'b00;
    req_unsigned_in = 1'b0; req_addr_in = 12'h0; req_wdata_in = 32'h0;
    rsp_ready_in = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_reset", 32'(req_ready_out), 32'd1);

    // Fill the test region with known data through word stores.
    for (int w = 0; w < 16; w++) do_req(1'b1, 2'b10, 1'b0, 12'(4 * w), $urandom, 0, rd);

    do_req(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 0, rd);
    do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0, rd);
    check_eq("word_load", rd, 32'hDEADBEEF);

    do_req(1'b1, 2'b10, 1'b0, 12'h020, 32'h11223344, 0, rd);
    do_req(1'b1, 2'b00, 1'b0, 12'h021, 32'h000000AA, 0, rd);
    check_eq("byte_merge_word", sram[12'h020 >> 2], 32'h1122AA44);
    do_req(1'b0, 2'b00, 1'b0, 12'h021, 32'h0, 0, rd);
    check_eq("lb_signed", rd, 32'hFFFFFFAA);
    do_req(1'b0, 2'b00, 1'b1, 12'h021, 32'h0, 0, rd);
    check_eq("lbu", rd, 32'h000000AA);

    do_req(1'b0, 2'b01, 1'b0, 12'h023, 32'h0, 0, rd);
    do_req(1'b0, 2'b11, 1'b0, 12'h020, 32'h0, 1, rd);
    do_req(1'b1, 2'b10, 1'b0, 12'h022, 32'h12345678, 0, rd);

    do_req(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 5, rd);

    // Reset in the middle of a read-modify-write must suppress the write.
    do_req(1'b1, 2'b10, 1'b0, 12'h030, 32'h11223344, 0, rd);
    wait_ready();
    we0 = we_cnt;
    req_valid_in = 1'b1; req_we_in = 1'b1; req_size_in = 2'b01;
    req_unsigned_in = 1'b0; req_addr_in = 12'h030; req_wdata_in = 32'h0000BEEF;
    @(posedge clk); #1;
    req_valid_in = 1'b0;
    @(posedge clk); #1;
    check_eq("in_merge_we_a", 32'(sram_we_a_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_mid_reset", 32'(req_ready_out), 32'd1);
    check_eq("no_write_on_reset", 32'(we_cnt - we0), 32'd0);
    check_eq("word_kept", sram[12'h030 >> 2], 32'h11223344);

    for (int t = 0; t < 200; t++)
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             12'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2), rd);

    for (int w = 0; w < 16; w++) check_word("final_mem", w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default ARCH (32): data width.
REQ-002 SHALL have parameter ADDR_W, default 12: byte address width into the dual-port SRAM.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid_in  in  1 and req_ready_out  out  1: request handshake.
REQ-006 SHALL have port req_we_in  in  1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size_in  in  2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned_in  in  1: load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port req_addr_in  in  ADDR_W: byte address.
REQ-010 SHALL have port req_wdata_in  in  DATA_W: store data, right-aligned.
REQ-011 SHALL have port rsp_valid_out  out  1 and rsp_ready_in  in  1: response handshake.
REQ-012 SHALL have port rsp_rdata_out  out  DATA_W and rsp_err_out  out  1: load result and error flag.
REQ-013 SHALL have ports sram_addr_a_out  out  ADDR_W, sram_din_a_out  out  DATA_W, sram_we_a_out  out  1: SRAM write port.
REQ-014 SHALL have ports sram_addr_b_out  out  ADDR_W, sram_en_b_out  out  1, sram_dout_b_in  in  DATA_W: SRAM read port; data is valid in the cycle after en_b is sampled high.

Function
REQ-015 SHALL implement FSM states IDLE, READ, CAPTURE, MERGE, WRITE, RESP.
REQ-016 SHALL assert req_ready_out only in IDLE; the request is registered on valid&ready.
REQ-017 SHALL drive SRAM addresses as the registered address with bits [1:0] forced to 0; little-endian lanes: byte lane addr[1:0], half lane addr[1].
REQ-018 SHALL flag misalignment (half with addr[0]=1, word with addr[1:0]!=0, or size 11): IDLE->RESP with rsp_err_out=1 and rsp_rdata_out=0; no SRAM access.
REQ-019 SHALL handle a load as IDLE->READ (en_b=1)->CAPTURE (register extracted, extended data)->RESP: rsp_valid_out in the 3rd cycle after handshake.
REQ-020 SHALL handle a word store as IDLE->WRITE (we_a=1, din=wdata)->RESP: rsp_valid_out in the 2nd cycle after handshake.
REQ-021 SHALL handle a byte/half store by read-modify-write, IDLE->READ->MERGE (we_a=1, din = read word with only the addressed lanes replaced)->RESP: rsp_valid_out in the 3rd cycle.
REQ-022 SHALL assert sram_we_a_out for exactly one cycle per store and sram_en_b_out for exactly one cycle per load or sub-word store; both SHALL be 0 in all other states.
REQ-023 SHALL hold rsp_valid_out, rsp_rdata_out and rsp_err_out stable in RESP until rsp_ready_in=1, then return to IDLE; rsp_rdata_out=0 for stores.
REQ-024 SHALL not accept a new request in the cycle rsp handshake completes (IDLE is entered first).

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE, req_ready_out=0, rsp_valid_out=0, rsp_rdata_out=0, rsp_err_out=0, sram_we_a_out=0, sram_en_b_out=0, all SRAM address/data outputs 0.
REQ-026 SHALL discard any in-flight request on reset, issuing no write, including a reset asserted during MERGE or WRITE.
REQ-027 SHALL assert req_ready_out from the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL place mem_size_t (byte/half/word/illegal) and the dmem_ctrl FSM state enum in friscv_pkg.
REQ-029 SHALL use one combinational sub-module mem_align for load lane extraction/extension and store lane merging.

Verification
REQ-030 Word store 0xDEADBEEF @0x010, then word load @0x010 -> rsp_rdata_out=0xDEADBEEF, err=0, load rsp_valid 3 cycles after handshake.
REQ-031 Word 0x11223344 @0x020; byte store 0xAA @0x021 -> memory word 0x1122AA44; signed byte load @0x021 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-032 Half load @0x023 -> err=1, rdata=0, response 1 cycle after handshake, we_a/en_b never asserted.
REQ-033 rsp_ready_in held 0 for 5 cycles -> rsp outputs stable, req_ready_out=0 throughout; release -> IDLE next cycle.
REQ-034 rst_n pulsed low during MERGE of half store 0xBEEF @0x030 (word 0x11223344) -> no write, word stays 0x11223344, outputs at reset values.
